adc_sampler_fifo: RTL
=====================

# adc_sampler_fifo

Downstream stage of the behavioural channel model. Samples the channel's real-valued output on each rising clock edge and quantizes it to a signed N-bit code with saturation. Codes go into a first-word-fall-through FIFO with a valid/ready output handshake. This block converts the analog-domain channel response into the digital sample stream the data-generation benches capture as ML training data.

## Interface
Parameters:
- NBIT, 6: ADC resolution; codes are signed two's complement.
- VREF, 1.0 (real): full-scale half-range; input span is [-VREF, +VREF).
- DEPTH, 16: FIFO depth in codes, power of two, ≥ 2.

Ports:
- clk  in  1  sampling clock; all state updates on rising edge.
- rstb  in  1  asynchronous active-low reset.
- vin  in  real  analog input, the channel output `y`.
- en  in  1  sample enable; vin is sampled only on edges where en=1.
- code_out  out  NBIT  FIFO head code, signed.
- out_valid  out  1  FIFO non-empty; code_out is valid.
- out_ready  in  1  consumer accepts head when out_valid & out_ready at an edge.
- clip  out  1  registered with each quantized code; 1 if that code saturated.
- overflow  out  1  sticky; a code was dropped because the FIFO was full.
- ovf_clr  in  1  synchronous clear of overflow.
- sample_cnt  out  32  count of samples taken (en=1 edges); wraps 2^32-1 → 0.

## Operation
- LSB = 2·VREF / 2^NBIT. Quantizer is mid-rise floor: q = floor(vin / LSB).
- Saturation: q > 2^(NBIT-1)-1 gives 2^(NBIT-1)-1; q < -2^(NBIT-1) gives -2^(NBIT-1). clip=1 in either case, else 0.
- Stage S1 (edge k, en=1): latch vin into a real register, set s1_valid, increment sample_cnt.
- Stage S2 (edge k+1): quantize the S1 value to code plus clip flag, set s2_valid.
- Push (edge k+2): if s2_valid, write {code, clip} into the FIFO.
  - FIFO not full, or a pop happens on the same edge: write accepted.
  - Otherwise: code dropped and overflow set.
- Pop: at an edge with out_valid & out_ready, advance the read pointer.
- FWFT: code_out and clip always show the head entry. When the FIFO is empty they hold the last popped value; zero after reset.
- Occupancy counter runs 0..DEPTH. Read and write pointers wrap modulo DEPTH.
- Simultaneous push and pop when empty: the push is stored and no pop occurs, because out_valid was 0.
- Simultaneous push and pop when full: both occur and occupancy stays DEPTH.
- overflow: set on a drop. ovf_clr=1 clears it, but a drop on the same edge wins (overflow stays 1).
- en=0: S1 holds and s1_valid=0. In-flight codes still drain through S2 into the FIFO.

## Timing
- Reset (rstb=0, asynchronous, immediate):
  - code_out=0, clip=0, out_valid=0, overflow=0, sample_cnt=0.
  - FIFO emptied, s1_valid=s2_valid=0, real registers cleared to 0.0.
- Release is synchronous to the next rising edge; the first sample is possible at that edge.
- Latency:
  - vin sampled at edge k appears on code_out with out_valid=1 immediately after edge k+2, when the FIFO was empty.
  - If the FIFO was not empty, the code queues behind existing entries.
- Throughput: one code per cycle with out_ready held high; the FIFO never fills.
- Reset asserted mid-stream discards all pipeline and FIFO contents. No partial output after release.

## Test plan
- NBIT=6, VREF=1.0 (LSB=0.03125), FIFO empty, out_ready=1:
  - vin=0.1 at edge 0 → code_out=3, clip=0, out_valid=1 after edge 2.
  - vin=-0.1 → code_out=-4.
- Saturation:
  - vin=1.5 → code_out=31, clip=1.
  - vin=-2.0 → code_out=-32, clip=1.
  - vin=0.96875 → code_out=31, clip=0.
- Backpressure:
  - out_ready=0, en=1, 20 consecutive samples, DEPTH=16 → occupancy 16, overflow=1, samples 17–20 dropped.
  - Then out_ready=1 → exactly 16 codes drain in order; out_valid falls after the 16th pop.
- Full with simultaneous push/pop:
  - FIFO full, out_ready=1 for one cycle while S2 is valid → no drop, overflow stays 0, occupancy stays 16.
- ovf_clr:
  - Pulse ovf_clr with no drop → overflow=0 next edge.
  - Pulse ovf_clr on an edge with a drop → overflow stays 1.
- Reset mid-stream:
  - rstb low for half a cycle with 5 codes queued → out_valid=0 and code_out=0 immediately, sample_cnt=0.
  - After release with en=1 → first new code appears 2 edges after the first sampling edge.

Source files
------------

// File: rtl/adc_sampler_fifo_if.sv
// Output stream of adc_sampler_fifo: the FIFO head code and its clip flag,
// qualified by a valid/ready handshake.
interface adc_sampler_fifo_if #(
    parameter int NBIT = 6
);
    logic signed [NBIT-1:0] code_out;
    logic                   clip;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output code_out,
        output clip,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  code_out,
        input  clip,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/adc_sampler_fifo.sv
// Samples a real-valued channel output, quantizes it to a saturating signed
// NBIT code and queues {clip, code} in a first-word-fall-through FIFO.
module adc_sampler_fifo #(
    parameter int  NBIT  = 6,
    parameter real VREF  = 1.0,
    parameter int  DEPTH = 16
) (
    input  logic                clk,
    input  logic                rstb,
    input  real                 vin,
    input  logic                en,
    adc_sampler_fifo_if.master  out_if,
    output logic                overflow,
    input  logic                ovf_clr,
    output logic [31:0]         sample_cnt
);

    localparam real LSB   = 2.0 * VREF / real'(1 << NBIT);
    localparam int  QMAX  = (1 << (NBIT - 1)) - 1;
    localparam int  QMIN  = -(1 << (NBIT - 1));
    localparam int  AW    = $clog2(DEPTH);
    localparam int  CW    = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // S1: sampled analog value
    real               s1_val_q,   s1_val_d;
    logic              s1_valid_q, s1_valid_d;
    logic [31:0]       cnt_q,      cnt_d;

    // S2: quantized code
    logic [NBIT-1:0]   s2_code_q,  s2_code_d;
    logic              s2_clip_q,  s2_clip_d;
    logic              s2_valid_q, s2_valid_d;

    // FIFO state; entries are {clip, code}
    logic [NBIT:0]     mem_q [DEPTH];
    logic [AW-1:0]     rd_ptr_q,   rd_ptr_d;
    logic [AW-1:0]     wr_ptr_q,   wr_ptr_d;
    logic [CW-1:0]     count_q,    count_d;
    logic [NBIT:0]     last_q,     last_d;
    logic              ovf_q,      ovf_d;

    logic              empty, full, pop, push, drop;
    logic [NBIT:0]     head;
    real               q_r;
    int                q_i;

    always_comb begin
        s1_val_d   = s1_val_q;
        s1_valid_d = 1'b0;
        cnt_d      = cnt_q;
        if (en) begin
            s1_val_d   = vin;
            s1_valid_d = 1'b1;
            cnt_d      = cnt_q + 32'd1;
        end
    end

    // Saturation is decided in the real domain so out-of-range inputs
    // never overflow the integer conversion.
    always_comb begin
        q_r       = $floor(s1_val_q / LSB);
        s2_clip_d = 1'b0;
        if (q_r > real'(QMAX)) begin
            q_i       = QMAX;
            s2_clip_d = 1'b1;
        end else if (q_r < real'(QMIN)) begin
            q_i       = QMIN;
            s2_clip_d = 1'b1;
        end else begin
            q_i = $rtoi(q_r);
        end
        s2_code_d  = q_i[NBIT-1:0];
        s2_valid_d = s1_valid_q;
    end

    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == FULL_CNT);
        head  = mem_q[rd_ptr_q];
        pop   = !empty && out_if.out_ready;
        push  = s2_valid_q && (!full || pop);
        drop  = s2_valid_q && full && !pop;

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            last_d   = head;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        out_if.out_valid = !empty;
        out_if.code_out  = empty ? last_q[NBIT-1:0] : head[NBIT-1:0];
        out_if.clip      = empty ? last_q[NBIT]     : head[NBIT];
        overflow         = ovf_q;
        sample_cnt       = cnt_q;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            s1_val_q   <= 0.0;
            s1_valid_q <= 1'b0;
            cnt_q      <= '0;
            s2_code_q  <= '0;
            s2_clip_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            last_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            s1_val_q   <= s1_val_d;
            s1_valid_q <= s1_valid_d;
            cnt_q      <= cnt_d;
            s2_code_q  <= s2_code_d;
            s2_clip_q  <= s2_clip_d;
            s2_valid_q <= s2_valid_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            last_q     <= last_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage needs no reset: occupancy gates every read of it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {s2_clip_q, s2_code_q};
        end
    end

endmodule
